// File: rtl/sine_sequencer_if.sv
// Control and sample-memory addressing bundle for the quarter-wave sine sequencer.
// master drives enable/sync_clear/step and receives the table address stream; slave is the sequencer.
interface sine_sequencer_if;
  logic       enable;
  logic       sync_clear;
  logic [3:0] step;
  logic [7:0] read_address;
  logic [1:0] read_state;
  logic       sample_valid;
  logic       cycle_wrap;

  modport master (
    output enable, sync_clear, step,
    input  read_address, read_state, sample_valid, cycle_wrap
  );

  modport slave (
    input  enable, sync_clear, step,
    output read_address, read_state, sample_valid, cycle_wrap
  );
endinterface

// File: rtl/sine_sequencer.sv
// Quarter-wave sine table address sequencer: walks a 128-entry table up/down per quadrant.
// Macro SINE_SEQ_STEP_EN enables the step input; when undefined the step is fixed at 1.
module sine_sequencer #(
  parameter int TICK_DIV = 4
) (
  input logic             clk,
  input logic             rst_n,
  sine_sequencer_if.slave bus
);

  localparam logic [9:0] TICK_LAST = 10'(TICK_DIV - 1);

  logic [9:0] tick_reg;
  logic [6:0] addr_reg;
  logic [1:0] state_reg;
  logic       adv_pipe_reg;
  logic       sample_valid_reg;
  logic       cycle_wrap_reg;

  logic [3:0] step_eff;
  logic       advance;
  logic [8:0] addr9;
  logic [8:0] step9;
  logic [8:0] up_sum;
  logic [6:0] addr_next;
  logic [1:0] state_next;
  logic       wrap_next;

`ifdef SINE_SEQ_STEP_EN
  assign step_eff = bus.step;
`else
  logic step_unused;
  assign step_unused = ^bus.step;
  assign step_eff    = 4'd1;
`endif

  assign advance = bus.enable && !bus.sync_clear && (tick_reg == TICK_LAST);

  // 9-bit arithmetic so addr+step and the reflections never lose a carry.
  always_comb begin
    addr9      = {2'b00, addr_reg};
    step9      = {5'b00000, step_eff};
    up_sum     = addr9 + step9;
    addr_next  = addr_reg;
    state_next = state_reg;
    wrap_next  = 1'b0;
    if (!state_reg[0]) begin
      if (up_sum <= 9'd127) begin
        addr_next = up_sum[6:0];
      end else begin
        addr_next  = 7'(9'd255 - up_sum);
        state_next = state_reg + 2'd1;
        wrap_next  = (state_reg == 2'd3);
      end
    end else begin
      if (addr9 >= step9) begin
        addr_next = 7'(addr9 - step9);
      end else begin
        addr_next  = 7'(step9 - addr9 - 9'd1);
        state_next = state_reg + 2'd1;
        wrap_next  = (state_reg == 2'd3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg         <= '0;
      addr_reg         <= '0;
      state_reg        <= '0;
      adv_pipe_reg     <= 1'b0;
      sample_valid_reg <= 1'b0;
      cycle_wrap_reg   <= 1'b0;
    end else begin
      // The valid pipeline keeps running so an in-flight pulse survives disable/clear.
      adv_pipe_reg     <= advance;
      sample_valid_reg <= adv_pipe_reg;
      cycle_wrap_reg   <= advance && wrap_next;
      if (bus.sync_clear) begin
        tick_reg  <= '0;
        addr_reg  <= '0;
        state_reg <= '0;
      end else if (!bus.enable) begin
        tick_reg <= '0;
      end else if (tick_reg == TICK_LAST) begin
        tick_reg  <= '0;
        addr_reg  <= addr_next;
        state_reg <= state_next;
      end else begin
        tick_reg <= tick_reg + 10'd1;
      end
    end
  end

  assign bus.read_address = {1'b0, addr_reg};
  assign bus.read_state   = state_reg;
  assign bus.sample_valid = sample_valid_reg;
  assign bus.cycle_wrap   = cycle_wrap_reg;

endmodule

// File: tb/tb_sine_sequencer.sv
// Directed bench for sine_sequencer with TICK_DIV=4: startup, full 512-advance sweep,
// enable freeze, sync_clear, async reset, and the step-configuration behaviour.
module tb_sine_sequencer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   sv_cnt;
  int   cw_cnt;
  int   sv_mark;

  sine_sequencer_if bus ();

  sine_sequencer #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock, sampled 1 ns after the rising edge; one line per emitted sample.
  task automatic clk1();
    @(posedge clk);
    #1;
    if (bus.sample_valid === 1'b1) begin
      sv_cnt++;
      $display("sample t=%0t addr=%0d quad=%0d", $time, bus.read_address, bus.read_state);
    end
    if (bus.cycle_wrap === 1'b1) cw_cnt++;
  endtask

  initial begin
    int q;
    int j;
    int ea;
    total = 0; bad = 0; sv_cnt = 0; cw_cnt = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.sync_clear = 1'b0;
    bus.step = 4'd1;
    repeat (2) clk1();
    chk("rst_addr", 32'(bus.read_address), 0);
    chk("rst_state", 32'(bus.read_state), 0);
    chk("rst_valid", 32'(bus.sample_valid), 0);
    chk("rst_wrap", 32'(bus.cycle_wrap), 0);

    // Startup: first advance on the 4th enabled edge, valid one edge later.
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    repeat (3) clk1();
    chk("start_hold", 32'(bus.read_address), 0);
    clk1();
    chk("adv1_addr", 32'(bus.read_address), 1);
    chk("adv1_valid_lag", 32'(bus.sample_valid), 0);
    clk1();
    chk("adv1_valid", 32'(bus.sample_valid), 1);
    clk1();
    chk("adv1_valid_end", 32'(bus.sample_valid), 0);
    repeat (2) clk1();
    chk("adv2_addr", 32'(bus.read_address), 2);

    // Full waveform: advance k lands at quadrant (k/128)%4, index k%128 mirrored in odd quadrants.
    for (int k = 3; k <= 512; k++) begin
      repeat (4) clk1();
      q  = (k / 128) % 4;
      j  = k % 128;
      ea = (q % 2 == 1) ? 127 - j : j;
      chk("sweep_addr", 32'(bus.read_address), 32'(ea));
      chk("sweep_state", 32'(bus.read_state), 32'(q));
    end
    chk("wrap_pulse", 32'(bus.cycle_wrap), 1);
    clk1();
    chk("wrap_once", 32'(cw_cnt), 1);
    chk("wrap_end", 32'(bus.cycle_wrap), 0);
    chk("valid_count", 32'(sv_cnt), 512);

    // Freeze at 40: the in-flight pulse still appears, then nothing until re-enable.
    repeat (3 + 39 * 4) clk1();
    chk("at40", 32'(bus.read_address), 40);
    bus.enable = 1'b0;
    clk1();
    chk("inflight_valid", 32'(bus.sample_valid), 1);
    sv_mark = sv_cnt;
    repeat (9) clk1();
    chk("frozen_addr", 32'(bus.read_address), 40);
    chk("frozen_no_valid", 32'(sv_cnt), 32'(sv_mark));
    bus.enable = 1'b1;
    repeat (3) clk1();
    chk("reen_hold", 32'(bus.read_address), 40);
    clk1();
    chk("reen_adv", 32'(bus.read_address), 41);

    // Run to quadrant 11 at 127, then clear on the next advance cycle.
    repeat (343 * 4) clk1();
    chk("q3_addr", 32'(bus.read_address), 127);
    chk("q3_state", 32'(bus.read_state), 3);
    repeat (3) clk1();
    bus.sync_clear = 1'b1;
    clk1();
    bus.sync_clear = 1'b0;
    chk("clr_addr", 32'(bus.read_address), 0);
    chk("clr_state", 32'(bus.read_state), 0);
    chk("clr_no_wrap", 32'(bus.cycle_wrap), 0);
    clk1();
    chk("clr_no_valid", 32'(bus.sample_valid), 0);
    repeat (2) clk1();
    chk("clr_hold", 32'(bus.read_address), 0);
    clk1();
    chk("clr_restart", 32'(bus.read_address), 1);

    // Async reset between edges at address 77; the in-flight valid must be discarded.
    repeat (76 * 4) clk1();
    chk("at77", 32'(bus.read_address), 77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.read_address), 0);
    chk("arst_state", 32'(bus.read_state), 0);
    chk("arst_valid", 32'(bus.sample_valid), 0);
    chk("arst_wrap", 32'(bus.cycle_wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clk1();
    chk("arst_pipe_clear", 32'(bus.sample_valid), 0);
    repeat (2) clk1();
    chk("arst_hold", 32'(bus.read_address), 0);
    clk1();
    chk("arst_first_adv", 32'(bus.read_address), 1);

`ifdef SINE_SEQ_STEP_EN
    repeat (125 * 4) clk1();
    chk("at126", 32'(bus.read_address), 126);
    bus.step = 4'd4;
    repeat (4) clk1();
    chk("reflect_up_addr", 32'(bus.read_address), 125);
    chk("reflect_up_state", 32'(bus.read_state), 1);
    repeat (31 * 4) clk1();
    chk("at1_q1", 32'(bus.read_address), 1);
    repeat (4) clk1();
    chk("reflect_dn_addr", 32'(bus.read_address), 2);
    chk("reflect_dn_state", 32'(bus.read_state), 2);
    bus.step = 4'd0;
    repeat (4) clk1();
    chk("step0_addr", 32'(bus.read_address), 2);
    clk1();
    chk("step0_valid", 32'(bus.sample_valid), 1);
`else
    bus.step = 4'd5;
    for (int k = 2; k <= 5; k++) begin
      repeat (4) clk1();
      chk("step_ignored_addr", 32'(bus.read_address), 32'(k));
      chk("step_ignored_state", 32'(bus.read_state), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sine_sequencer.md
SINE_SEQUENCER -- requirements
Module: sine_sequencer

Interface
REQ-001 Parameter: TICK_DIV, default 4, clock cycles per sample advance (legal range 1..1023).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: enable  input  1  high = sequencer runs; low = freeze position.
REQ-005 Port: sync_clear  input  1  synchronous restart to start of waveform.
REQ-006 Port: step  input  4  address increment per advance, 0..15.
REQ-007 Port: read_address  output  8  quarter-wave table address to the sample memory; bit 7 always 0.
REQ-008 Port: read_state  output  2  quadrant code to the sample memory: 00, 01, 10, 11.
REQ-009 Port: sample_valid  output  1  one-cycle pulse; sample memory output corresponds to the latest advance.
REQ-010 Port: cycle_wrap  output  1  one-cycle pulse on quadrant 11 -> 00 transition.

Function
REQ-011 The block SHALL contain a tick counter that counts 0..TICK_DIV-1 while enable=1 and generates an advance on the cycle it holds TICK_DIV-1, then returns to 0.
REQ-012 While enable=0, the block SHALL clear the tick counter to 0, hold read_address and read_state, and generate no advance.
REQ-013 sync_clear=1 SHALL, on the next edge, set read_address=0, read_state=00, and tick=0; it SHALL suppress any advance that cycle and override enable.
REQ-014 Direction SHALL be up in quadrants 00 and 10, and down in quadrants 01 and 11.
REQ-015 Up advance: let n = addr+step; if n<=127, addr<=n; else addr<=255-n and quadrant increments.
REQ-016 Down advance: if addr>=step, addr<=addr-step; else addr<=step-addr-1 and quadrant increments.
REQ-017 Quadrant increment SHALL wrap 11 -> 00; the arithmetic SHALL use at least 9 bits, and no intermediate SHALL truncate.
REQ-018 With step=1, each quadrant SHALL visit all 128 addresses once (endpoints repeated at reflections), giving 512 advances per waveform cycle.
REQ-019 step=0 SHALL still generate advances (sample_valid pulses) with the address and quadrant unchanged.
REQ-020 step SHALL be sampled on the advance cycle only.
REQ-021 read_address and read_state SHALL be registered and update on the edge at which the advance occurs.
REQ-022 sample_valid SHALL pulse for exactly one cycle, one cycle after each advance, to match the memory's 1-cycle read latency.
REQ-023 A sample_valid pulse already in flight SHALL still be emitted if enable drops or sync_clear asserts.
REQ-024 cycle_wrap SHALL be registered and asserted in the same cycle that read_state becomes 00 via wrap, but not via sync_clear.

Reset
REQ-025 On rst_n=0, asynchronously: read_address=0, read_state=00, sample_valid=0, cycle_wrap=0, tick=0, and the sample_valid pipeline cleared.
REQ-026 Reset deasserted mid-waveform SHALL restart from address 0, quadrant 00, with the first advance TICK_DIV enabled cycles later.

Configuration
REQ-027 Macro SINE_SEQ_STEP_EN defined: step port functional as specified.
REQ-028 Macro SINE_SEQ_STEP_EN undefined: step port present but ignored; effective step fixed at 1; all other behaviour identical.

Verification
REQ-029 Reset, then enable=1, TICK_DIV=4, step=1 -> read_address 0,1,2 at advances every 4 cycles; sample_valid lags each advance by 1 cycle.
REQ-030 step=1 run, 512 advances -> addresses 0..127 in 00, 127..0 in 01, 0..127 in 10, 127..0 in 11, then cycle_wrap pulse once as read_state returns to 00.
REQ-031 Quadrant 00, addr=126, step=4, advance -> addr=125, read_state=01; quadrant 01, addr=1, step=4, advance -> addr=2, read_state=10.
REQ-032 enable dropped for 10 cycles mid-quadrant at addr=40 -> addr stays 40, no sample_valid after the in-flight one; re-enable -> next advance after 4 cycles to 41.
REQ-033 sync_clear coincident with an advance at addr=127 in quadrant 11 -> addr=0, state=00, no cycle_wrap, no new sample_valid.
REQ-034 rst_n pulsed low between clock edges at addr=77 -> all outputs 0 immediately; macro undefined with step=5 -> sequence identical to step=1.
